mux_conf_sequencer: RTL and testbench
=====================================

Name: mux_conf_sequencer

Overview:
- Upstream control stage for top_design_mux, clocked from wb_clk_i.
- Synchronises the LA-driven mux configuration strobe, design select and reset controls.
- Commits design-select changes on strobe edges and sequences a timed auto-reset into the newly selected design.
- Drives the mux with a clean, glitch-free select plus per-design reset lines.

Parameters:
- NUM_DESIGNS, 16: number of selectable designs and width of the per-design reset vector; valid range 2..16.
- RESET_CYCLES, 8: cycles the auto-reset is held on a newly selected design; valid range 1..255.
- SYNC_STAGES, 2: flip-flop depth of every input synchroniser; valid range 2..3.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_n  in  1  asynchronous, active-low reset.
- i_sys_rst  in  1  system reset request (wb_rst_i); synchronous to the clock.
- i_conf_clk  in  1  LA config strobe (la_data_in[63]); asynchronous.
- i_sel  in  4  requested design (LA[52:49]); asynchronous.
- i_sys_reset_enb  in  1  active low: allows i_sys_rst to reset the selected design.
- i_auto_reset_enb  in  1  active low: enables the auto-reset sequence on a select change.
- i_design_reset  in  8  manual per-design reset (LA[62:55]); asynchronous; bit k maps to design k.
- o_sel  out  4  committed design select to the mux.
- o_design_rst  out  NUM_DESIGNS  active-high reset, one bit per design.
- o_busy  out  1  auto-reset sequence in progress.
- o_pending  out  1  a captured select is waiting to be committed.

Behaviour:
- Reset (wb_rst_n low, asynchronous):
  - o_sel = 0, o_design_rst = all ones, o_busy = 0, o_pending = 0.
  - FSM = IDLE; all synchroniser flops = 0.
- Synchronisers: i_conf_clk, i_sel, i_auto_reset_enb, i_sys_reset_enb and i_design_reset each pass through SYNC_STAGES flops.
- Strobe detection:
  - Strobe = synced conf_clk rising edge (current 1, previous 0).
  - Captures synced sel into the pending register and sets o_pending, one cycle after edge detection.
- FSM:
  - IDLE:
    - pending with sel == o_sel: clear pending, stay in IDLE.
    - pending with sel != o_sel: o_sel <= pending sel, clear pending. If auto_reset_enb == 0, counter <= RESET_CYCLES-1 and go to ASSERT; otherwise stay in IDLE.
  - ASSERT: o_busy = 1; auto-reset bit of o_sel asserted; counter decrements each cycle. When counter == 0, go to IDLE on the next cycle. Total reset assertion is exactly RESET_CYCLES cycles.
- Strobe during ASSERT:
  - Captured into pending; it does not interrupt the sequence.
  - A further strobe overwrites pending (last wins, one-deep).
  - The pending select is processed in IDLE on the cycle after ASSERT exits.
- Strobe and pending-consume in the same cycle: the new capture wins, and pending stays set with the new value.
- Select values >= NUM_DESIGNS:
  - Committed to o_sel normally; no auto-reset sequence is run.
  - Reset bits indexed >= NUM_DESIGNS do not exist.
- o_design_rst[k] is registered and is the OR of:
  - the FSM auto-reset term, when k == o_sel;
  - the synced i_design_reset[k], for k < 8;
  - (i_sys_rst AND synced sys_reset_enb == 0), when k == o_sel.
- First cycle after reset release: o_design_rst is recomputed from the terms above (i.e. deasserts unless a term holds).
- wb_rst_n asserted mid-ASSERT: sequence aborts immediately and all outputs take their reset values.
- o_sel changes only in IDLE, so the mux select is a single clean transition per commit.

Optional Feature:
- Macro MUX_CONF_STATUS_EN.
- When defined, adds:
  - o_switch_count (8 bits): increments on every o_sel commit where the value changed; wraps 255 -> 0.
  - o_overrun (1 bit): sticky; set when a strobe overwrites a still-pending select; cleared only by wb_rst_n.
  - Both reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold wb_rst_n low, then release with all LA inputs 0 -> o_design_rst = all ones during reset, all zero on the first post-reset cycle; o_sel = 0; o_busy = 0.
- Auto-reset switch: auto_reset_enb = 0, i_sel = 3, pulse i_conf_clk -> o_sel = 3; o_design_rst[3] high for exactly 8 cycles; o_busy high for the same 8 cycles; no other bits high.
- Auto-reset disabled: auto_reset_enb = 1, i_sel = 5, pulse strobe -> o_sel = 5; o_design_rst stays 0; o_busy stays 0.
- Strobes during ASSERT: pulse strobe with i_sel = 2, then i_sel = 7, then i_sel = 9, all while busy -> o_sel = 2 sequence completes; o_sel = 9 commits next with its own 8-cycle reset; o_overrun = 1 if the macro is enabled.
- Same-select strobe: strobe with i_sel equal to o_sel -> no reset pulse; o_pending clears within 1 cycle; o_switch_count is unchanged.
- System reset path: i_sys_reset_enb = 0 with i_sys_rst high for 4 cycles, and i_design_reset[6] = 1 -> o_design_rst[o_sel] high for those 4 cycles; o_design_rst[6] high after the synchroniser delay; reset mid-ASSERT clears o_busy asynchronously.

Source files
------------

// File: rtl/mux_conf_sequencer.sv
// Control stage ahead of top_design_mux: synchronises LA controls, commits design selects
// and runs a timed auto-reset into each new design. Optional status outputs: MUX_CONF_STATUS_EN.
module mux_conf_sequencer #(
    parameter int NUM_DESIGNS  = 16,
    parameter int RESET_CYCLES = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n,
    input  logic                   i_sys_rst,
    input  logic                   i_conf_clk,
    input  logic [3:0]             i_sel,
    input  logic                   i_sys_reset_enb,
    input  logic                   i_auto_reset_enb,
    input  logic [7:0]             i_design_reset,
    output logic [3:0]             o_sel,
    output logic [NUM_DESIGNS-1:0] o_design_rst,
    output logic                   o_busy,
    output logic                   o_pending,
    output logic                   o_fsm_state
`ifdef MUX_CONF_STATUS_EN
    ,
    output logic [7:0]             o_switch_count,
    output logic                   o_overrun
`endif
);

    localparam int         LP_SW = 15;
    localparam logic [4:0] LP_ND = 5'(NUM_DESIGNS);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } state_t;

    logic [LP_SW-1:0]                  w_async;
    logic [SYNC_STAGES-1:0][LP_SW-1:0] r_sync;
    logic [LP_SW-1:0]                  w_synced;
    logic                              w_conf_s;
    logic [3:0]                        w_sel_s;
    logic                              w_auto_enb_s;
    logic                              w_sys_enb_s;
    logic [7:0]                        w_dr_s;
    logic                              r_conf_prev;
    logic                              w_strobe;

    state_t                            r_state;
    logic [3:0]                        r_sel;
    logic [7:0]                        r_cnt;
    logic                              r_busy;
    logic [NUM_DESIGNS-1:0]            r_design_rst;
    logic                              r_pending;
    logic [3:0]                        r_pend_sel;

    logic [15:0]                       w_dr_ext;
    logic [NUM_DESIGNS-1:0]            w_rst_base;
    logic                              w_consume;
    logic                              w_commit;
    logic                              w_auto_ok;

    function automatic logic [NUM_DESIGNS-1:0] f_onehot(input logic [3:0] sel);
        logic [15:0] v;
        v = 16'h0001 << sel;
        return v[NUM_DESIGNS-1:0];
    endfunction

    assign w_async = {i_conf_clk, i_sel, i_auto_reset_enb, i_sys_reset_enb, i_design_reset};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_sync      <= '0;
            r_conf_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], w_async};
            r_conf_prev <= w_conf_s;
        end
    end

    assign w_synced     = r_sync[SYNC_STAGES-1];
    assign w_conf_s     = w_synced[14];
    assign w_sel_s      = w_synced[13:10];
    assign w_auto_enb_s = w_synced[9];
    assign w_sys_enb_s  = w_synced[8];
    assign w_dr_s       = w_synced[7:0];
    assign w_strobe     = w_conf_s & ~r_conf_prev;

    // Reset terms that do not depend on the sequencer; manual resets only exist for designs 0..7.
    assign w_dr_ext = {8'h00, w_dr_s};
    always_comb begin
        w_rst_base = w_dr_ext[NUM_DESIGNS-1:0];
        if (i_sys_rst && !w_sys_enb_s) begin
            w_rst_base = w_rst_base | f_onehot(r_sel);
        end
    end

    // r_pending is the valid flag for r_pend_sel; the IDLE state is its only consumer and takes
    // it in the cycle it is seen, while a strobe in that same cycle re-arms it with the new select.
    assign w_consume = (r_state == ST_IDLE) && r_pending;
    assign w_commit  = w_consume && (r_pend_sel != r_sel);
    assign w_auto_ok = !w_auto_enb_s && ({1'b0, r_pend_sel} < LP_ND);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= 4'd0;
            r_cnt        <= 8'd0;
            r_busy       <= 1'b0;
            r_design_rst <= '1;
            r_pending    <= 1'b0;
            r_pend_sel   <= 4'd0;
        end else begin
            r_design_rst <= w_rst_base;
            case (r_state)
                ST_IDLE: begin
                    if (w_commit) begin
                        r_sel <= r_pend_sel;
                        if (w_auto_ok) begin
                            r_cnt        <= 8'(RESET_CYCLES - 1);
                            r_state      <= ST_ASSERT;
                            r_busy       <= 1'b1;
                            r_design_rst <= w_rst_base | f_onehot(r_pend_sel);
                        end
                    end
                end
                ST_ASSERT: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt        <= r_cnt - 8'd1;
                        r_design_rst <= w_rst_base | f_onehot(r_sel);
                    end
                end
            endcase
            if (w_strobe) begin
                r_pending  <= 1'b1;
                r_pend_sel <= w_sel_s;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_sel        = r_sel;
    assign o_design_rst = r_design_rst;
    assign o_busy       = r_busy;
    assign o_pending    = r_pending;
    assign o_fsm_state  = r_state;

`ifdef MUX_CONF_STATUS_EN
    logic [7:0] r_switch_count;
    logic       r_overrun;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_switch_count <= 8'd0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_commit) begin
                r_switch_count <= r_switch_count + 8'd1;
            end
            if (w_strobe && r_pending && !w_consume) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_switch_count = r_switch_count;
    assign o_overrun      = r_overrun;
`endif

endmodule

// File: tb/tb_mux_conf_sequencer.sv
// Directed bench for mux_conf_sequencer: select commits, auto-reset timing, reset paths.
module tb_mux_conf_sequencer;

    logic        clk = 1'b0;
    logic        wb_rst_n;
    logic        i_sys_rst;
    logic        i_conf_clk;
    logic [3:0]  i_sel;
    logic        i_sys_reset_enb;
    logic        i_auto_reset_enb;
    logic [7:0]  i_design_reset;
    logic [3:0]  o_sel;
    logic [15:0] o_design_rst;
    logic        o_busy;
    logic        o_pending;
    logic        o_fsm_state;
`ifdef MUX_CONF_STATUS_EN
    logic [7:0]  o_switch_count;
    logic        o_overrun;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  mon_prev = 4'd0;

    mux_conf_sequencer dut (
        .wb_clk_i         (clk),
        .wb_rst_n         (wb_rst_n),
        .i_sys_rst        (i_sys_rst),
        .i_conf_clk       (i_conf_clk),
        .i_sel            (i_sel),
        .i_sys_reset_enb  (i_sys_reset_enb),
        .i_auto_reset_enb (i_auto_reset_enb),
        .i_design_reset   (i_design_reset),
        .o_sel            (o_sel),
        .o_design_rst     (o_design_rst),
        .o_busy           (o_busy),
        .o_pending        (o_pending),
        .o_fsm_state      (o_fsm_state)
`ifdef MUX_CONF_STATUS_EN
        ,
        .o_switch_count   (o_switch_count),
        .o_overrun        (o_overrun)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic pulse(input logic [3:0] s);
        i_sel = s;
        tick(3);
        i_conf_clk = 1'b1;
        tick(3);
        i_conf_clk = 1'b0;
    endtask

    task automatic fast_pulse(input logic [3:0] s);
        i_sel      = s;
        i_conf_clk = 1'b1;
        tick(2);
        i_conf_clk = 1'b0;
        tick(2);
    endtask

    // Scoreboard: every change of o_sel outside reset must be the next expected commit
    always @(negedge clk) begin
        logic [31:0] e;
        if (!wb_rst_n) begin
            mon_prev = 4'd0;
        end else if (o_sel !== mon_prev) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 32'hDEAD;
            check("commit", {28'd0, o_sel}, e);
            mon_prev = o_sel;
        end
    end

    initial begin
        int busy_n, r_n, other_n;

        wb_rst_n         = 1'b0;
        i_sys_rst        = 1'b0;
        i_conf_clk       = 1'b0;
        i_sel            = 4'd0;
        i_sys_reset_enb  = 1'b0;
        i_auto_reset_enb = 1'b0;
        i_design_reset   = 8'h00;

        // Reset state
        tick(3);
        check("rst_design_rst", o_design_rst, 16'hFFFF);
        check("rst_sel", o_sel, 0);
        check("rst_busy", o_busy, 0);
        check("rst_pending", o_pending, 0);
        wb_rst_n = 1'b1;
        tick(1);
        check("post_rst_design_rst", o_design_rst, 16'h0000);
        check("post_rst_busy", o_busy, 0);

        // Auto-reset switch to design 3
        exp_q.push_back(3);
        pulse(4'd3);
        check("sw3_pending", o_pending, 1);
        check("sw3_sel_before", o_sel, 0);
        tick(1);
        check("sw3_sel", o_sel, 3);
        check("sw3_pending_clr", o_pending, 0);
        check("sw3_state", o_fsm_state, 1);
        busy_n = 0; r_n = 0; other_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_busy) busy_n++;
            if (o_design_rst[3]) r_n++;
            if ((o_design_rst & ~16'h0008) != 16'h0000) other_n++;
            tick(1);
        end
        check("sw3_busy_cycles", busy_n, 8);
        check("sw3_rst_cycles", r_n, 8);
        check("sw3_other_bits", other_n, 0);

        // Auto-reset disabled: switch to 5 without any reset pulse
        i_auto_reset_enb = 1'b1;
        exp_q.push_back(5);
        pulse(4'd5);
        tick(1);
        check("sw5_sel", o_sel, 5);
        busy_n = 0; other_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_busy) busy_n++;
            if (o_design_rst != 16'h0000) other_n++;
            tick(1);
        end
        check("sw5_busy_cycles", busy_n, 0);
        check("sw5_rst_cycles", other_n, 0);
        i_auto_reset_enb = 1'b0;
        tick(3);

        // Strobes 2, 7, 9 back to back: 2 runs, 9 overwrites 7 and commits after
        exp_q.push_back(2);
        exp_q.push_back(9);
        fast_pulse(4'd2);
        check("seq2_sel", o_sel, 2);
        check("seq2_busy", o_busy, 1);
        check("seq2_rst", o_design_rst, 16'h0004);
        fast_pulse(4'd7);
        check("seq7_pending", o_pending, 1);
        check("seq7_sel", o_sel, 2);
        check("seq7_busy", o_busy, 1);
        fast_pulse(4'd9);
        check("seq9_exit_busy", o_busy, 0);
        check("seq9_exit_sel", o_sel, 2);
        check("seq9_exit_pending", o_pending, 1);
        tick(1);
        check("seq9_sel", o_sel, 9);
        check("seq9_busy", o_busy, 1);
        check("seq9_pending", o_pending, 0);
        check("seq9_rst", o_design_rst, 16'h0200);
`ifdef MUX_CONF_STATUS_EN
        check("seq_overrun", o_overrun, 1);
        check("seq_switch_count", o_switch_count, 4);
`endif
        busy_n = 0; r_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!o_busy) break;
            busy_n++;
            if (o_design_rst == 16'h0200) r_n++;
            tick(1);
        end
        check("seq9_busy_cycles", busy_n, 8);
        check("seq9_rst_cycles", r_n, 8);
        check("seq9_rst_after", o_design_rst, 16'h0000);

        // Same-select strobe
        pulse(4'd9);
        check("same_pending", o_pending, 1);
        tick(1);
        check("same_pending_clr", o_pending, 0);
        check("same_busy", o_busy, 0);
        other_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_design_rst != 16'h0000) other_n++;
            tick(1);
        end
        check("same_rst_cycles", other_n, 0);
`ifdef MUX_CONF_STATUS_EN
        check("same_switch_count", o_switch_count, 4);
`endif

        // Manual and system reset paths
        i_design_reset = 8'h40;
        tick(2);
        check("dr6_sync_delay", o_design_rst, 16'h0000);
        tick(1);
        check("dr6_rst", o_design_rst, 16'h0040);
        i_sys_rst = 1'b1;
        r_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (i == 3) i_sys_rst = 1'b0;
            if (o_design_rst[9]) r_n++;
        end
        check("sys_rst_cycles", r_n, 4);
        check("sys_rst_after", o_design_rst, 16'h0040);
        i_sys_reset_enb = 1'b1;
        tick(3);
        i_sys_rst = 1'b1;
        tick(2);
        check("sys_rst_blocked", o_design_rst, 16'h0040);
        i_sys_rst       = 1'b0;
        i_sys_reset_enb = 1'b0;
        i_design_reset  = 8'h00;
        tick(3);
        check("dr_clear", o_design_rst, 16'h0000);

        // Asynchronous reset in the middle of an auto-reset sequence
        exp_q.push_back(4);
        pulse(4'd4);
        tick(2);
        check("abort_busy_before", o_busy, 1);
        check("abort_rst_before", o_design_rst, 16'h0010);
        wb_rst_n = 1'b0;
        #1;
        check("abort_busy", o_busy, 0);
        check("abort_sel", o_sel, 0);
        check("abort_rst", o_design_rst, 16'hFFFF);
        check("abort_pending", o_pending, 0);
        check("abort_state", o_fsm_state, 0);
        tick(2);
        wb_rst_n = 1'b1;
        tick(1);
        check("abort_post_rst", o_design_rst, 16'h0000);
        check("abort_post_busy", o_busy, 0);
        check("abort_post_sel", o_sel, 0);
`ifdef MUX_CONF_STATUS_EN
        check("abort_switch_count", o_switch_count, 0);
        check("abort_overrun", o_overrun, 0);
`endif
        tick(2);
        check("commit_q_empty", exp_q.size(), 0);

        // Report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
